// File: rtl/regfile_wen_arbiter.sv
// regfile_wen_arbiter
// Arbitrates CPU and DMA register-file write requests, decodes the winning
// index into a registered one-hot write enable, applies a per-register
// write-protect mask and records illegal writes in a sticky error flag.
//
// Handshake: a requester raises req with a stable addr and holds both until
// the cycle its gnt is high; that cycle consumes the request, so a req seen
// while its own gnt is high is ignored and never issued twice.
module regfile_wen_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int N_REGS   = 32,
   parameter bit DMA_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_gnt,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   output logic              dma_gnt,
   input  logic [N_REGS-1:0] wp_mask,
   output logic [N_REGS-1:0] wen,
   output logic              wen_valid,
   output logic              wen_src,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr,
   input  logic              err_clr
);

   logic              cpu_elig;
   logic              dma_elig;
   logic              any_elig;
   logic              win_dma;
   logic              win_legal;
   logic              illegal;
   logic [ADDR_W-1:0] win_addr;
   logic [N_REGS-1:0] dec;
   // 1 = DMA won the most recent grant; resets to DMA so the CPU wins first.
   logic              last_dma;

   // Eligibility and winner selection for this decision cycle.
   always_comb begin
      cpu_elig = cpu_req & ~cpu_gnt;
      dma_elig = dma_req & ~dma_gnt;
      any_elig = cpu_elig | dma_elig;
      if (cpu_elig && dma_elig) begin
         win_dma = DMA_PRIO ? 1'b1 : ~last_dma;
      end else begin
         win_dma = dma_elig;
      end
      win_addr = win_dma ? dma_addr : cpu_addr;
   end

   // One-hot decode; indices at or above N_REGS never match, so they are illegal.
   always_comb begin
      dec       = '0;
      win_legal = 1'b0;
      for (int i = 0; i < N_REGS; i++) begin
         if ((win_addr == ADDR_W'(i)) && !wp_mask[i]) begin
            dec[i]    = 1'b1;
            win_legal = 1'b1;
         end
      end
      illegal = any_elig & ~win_legal;
   end

   // Registered issue: grants, write enable and arbitration history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_gnt   <= 1'b0;
         dma_gnt   <= 1'b0;
         wen       <= '0;
         wen_valid <= 1'b0;
         wen_src   <= 1'b0;
         last_dma  <= 1'b1;
      end else begin
         cpu_gnt   <= any_elig & ~win_dma;
         dma_gnt   <= any_elig & win_dma;
         wen       <= any_elig ? dec : '0;
         wen_valid <= any_elig & win_legal;
         if (any_elig) begin
            wen_src  <= win_dma;
            last_dma <= win_dma;
         end
      end
   end

   // Sticky error; a new illegal write takes precedence over a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err      <= 1'b0;
         err_addr <= '0;
      end else if (illegal) begin
         err <= 1'b1;
         if (!err || err_clr) begin
            err_addr <= win_addr;
         end
      end else if (err_clr) begin
         err      <= 1'b0;
         err_addr <= '0;
      end
   end

endmodule

// File: tb/tb_regfile_wen_arbiter.sv
// Testbench for regfile_wen_arbiter: a default round-robin instance (dut0)
// and a 24-register fixed-DMA-priority instance (dut1).
module tb_regfile_wen_arbiter;

   logic clk;
   logic rst;

   logic        c0_req, d0_req, clr0;
   logic [4:0]  c0_addr, d0_addr;
   logic [31:0] wp0;
   logic        c0_gnt, d0_gnt, val0, src0, err0;
   logic [31:0] wen0;
   logic [4:0]  ea0;

   logic        c1_req, d1_req, clr1;
   logic [4:0]  c1_addr, d1_addr;
   logic [23:0] wp1;
   logic        c1_gnt, d1_gnt, val1, src1, err1;
   logic [23:0] wen1;
   logic [4:0]  ea1;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_wen_arbiter dut0 (
      .clk(clk), .rst(rst),
      .cpu_req(c0_req), .cpu_addr(c0_addr), .cpu_gnt(c0_gnt),
      .dma_req(d0_req), .dma_addr(d0_addr), .dma_gnt(d0_gnt),
      .wp_mask(wp0), .wen(wen0), .wen_valid(val0), .wen_src(src0),
      .err(err0), .err_addr(ea0), .err_clr(clr0)
   );

   regfile_wen_arbiter #(.ADDR_W(5), .N_REGS(24), .DMA_PRIO(1'b1)) dut1 (
      .clk(clk), .rst(rst),
      .cpu_req(c1_req), .cpu_addr(c1_addr), .cpu_gnt(c1_gnt),
      .dma_req(d1_req), .dma_addr(d1_addr), .dma_gnt(d1_gnt),
      .wp_mask(wp1), .wen(wen1), .wen_valid(val1), .wen_src(src1),
      .err(err1), .err_addr(ea1), .err_clr(clr1)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int inst, input logic creq, input logic [4:0] caddr,
                         input logic dreq, input logic [4:0] daddr,
                         input logic [31:0] wp, input logic clr);
      if (inst == 0) begin
         c0_req = creq; c0_addr = caddr; d0_req = dreq; d0_addr = daddr;
         wp0 = wp; clr0 = clr;
      end else begin
         c1_req = creq; c1_addr = caddr; d1_req = dreq; d1_addr = daddr;
         wp1 = wp[23:0]; clr1 = clr;
      end
   endtask

   // Bundle layout: {cpu_gnt, dma_gnt, wen[31:0], wen_valid, wen_src, err, err_addr}
   task automatic get_out(input int inst, output logic [41:0] b);
      if (inst == 0) b = {c0_gnt, d0_gnt, wen0, val0, src0, err0, ea0};
      else           b = {c1_gnt, d1_gnt, {8'h00, wen1}, val1, src1, err1, ea1};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      set_in(1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [41:0] got;
      rst = 1'b1;
      set_in(0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
      set_in(1, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      tick();
      for (int inst = 0; inst < 2; inst++) begin
         get_out(inst, got);
         n_tests++;
         if (got !== 42'h0) begin
            n_fail++;
            $display("FAIL reset_values inst%0d got=%h exp=%h", inst, got, 42'h0);
         end
      end
      rst = 1'b0;
      tick();
      get_out(0, got);
      n_tests++;
      if (got !== {1'b1, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 5'd0}) begin
         n_fail++;
         $display("FAIL first_write got=%h exp=%h", got,
                  {1'b1, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 5'd0});
      end
   endtask

   task automatic test_round_robin();
      logic [41:0] got;
      logic [41:0] exp_v [3];
      exp_v[0] = {1'b1, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0, 5'd0};
      exp_v[1] = {1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 5'd0};
      exp_v[2] = {1'b1, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0, 5'd0};
      do_reset();
      set_in(0, 1'b1, 5'd1, 1'b1, 5'd2, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         get_out(0, got);
         n_tests++;
         if (got !== exp_v[k]) begin
            n_fail++;
            $display("FAIL round_robin step%0d got=%h exp=%h", k, got, exp_v[k]);
         end
      end
   endtask

   task automatic test_dma_prio();
      logic [41:0] got;
      logic [41:0] exp_v [4];
      exp_v[0] = {1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 5'd0};
      exp_v[1] = {1'b1, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0, 5'd0};
      exp_v[2] = exp_v[0];
      exp_v[3] = exp_v[1];
      do_reset();
      set_in(1, 1'b1, 5'd1, 1'b1, 5'd2, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         get_out(1, got);
         n_tests++;
         if (got !== exp_v[k]) begin
            n_fail++;
            $display("FAIL dma_prio step%0d got=%h exp=%h", k, got, exp_v[k]);
         end
      end
   endtask

   task automatic test_write_protect();
      logic [41:0] got;
      logic [41:0] exp_v [3];
      exp_v[0] = {1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd4};
      exp_v[1] = {1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 5'd4};
      exp_v[2] = {1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd4};
      do_reset();
      set_in(0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h10, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         get_out(0, got);
         n_tests++;
         if (got !== exp_v[k]) begin
            n_fail++;
            $display("FAIL write_protect step%0d got=%h exp=%h", k, got, exp_v[k]);
         end
         if (k == 0) set_in(0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h10, 1'b0);
         else        set_in(0, 1'b0, 5'd0, 1'b0, 5'd5, 32'h10, 1'b0);
      end
   endtask

   task automatic test_out_of_range();
      logic [41:0] got;
      logic [41:0] exp_v [4];
      exp_v[0] = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd30};
      exp_v[1] = {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd30};
      exp_v[2] = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd25};
      exp_v[3] = {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0};
      do_reset();
      set_in(1, 1'b1, 5'd30, 1'b0, 5'd0, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         get_out(1, got);
         n_tests++;
         if (got !== exp_v[k]) begin
            n_fail++;
            $display("FAIL out_of_range step%0d got=%h exp=%h", k, got, exp_v[k]);
         end
         case (k)
            0: set_in(1, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 1'b0);
            1: set_in(1, 1'b1, 5'd25, 1'b0, 5'd0, 32'h0, 1'b1);
            default: set_in(1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
         endcase
      end
   endtask

   task automatic test_reset_mid();
      logic [41:0] got;
      do_reset();
      rst = 1'b1;
      set_in(0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0, 1'b0);
      tick();
      get_out(0, got);
      n_tests++;
      if (got !== 42'h0) begin
         n_fail++;
         $display("FAIL reset_mid_held got=%h exp=%h", got, 42'h0);
      end
      rst = 1'b0;
      tick();
      get_out(0, got);
      n_tests++;
      if (got !== {1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 5'd0}) begin
         n_fail++;
         $display("FAIL reset_mid_release got=%h exp=%h", got,
                  {1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 5'd0});
      end
   endtask

   // Random requesters obeying the handshake, checked every cycle against a
   // reference model built from the arbitration and error rules.
   task automatic test_random(input int inst, input int cycles);
      int          n_regs;
      bit          prio;
      bit          m_last_dma, m_pc, m_pd, m_src, m_err;
      logic [4:0]  m_ea;
      bit          creq, dreq, clr, ce, de, wd, legal;
      logic [4:0]  ca, da, wa;
      logic [31:0] wp, ewen;
      logic [41:0] got, exp_b;
      n_regs = (inst == 0) ? 32 : 24;
      prio   = (inst == 1);
      m_last_dma = 1'b1; m_pc = 1'b0; m_pd = 1'b0; m_src = 1'b0;
      m_err = 1'b0; m_ea = 5'd0;
      creq = 1'b0; dreq = 1'b0; ca = 5'd0; da = 5'd0;
      do_reset();
      for (int cyc = 0; cyc < cycles; cyc++) begin
         if (!creq || m_pc) begin
            creq = ($urandom_range(0, 2) != 0);
            ca   = 5'($urandom_range(0, 31));
         end
         if (!dreq || m_pd) begin
            dreq = ($urandom_range(0, 2) != 0);
            da   = 5'($urandom_range(0, 31));
         end
         wp  = $urandom & $urandom & $urandom;
         if (n_regs == 24) wp[31:24] = 8'h00;
         clr = ($urandom_range(0, 7) == 0);
         set_in(inst, creq, ca, dreq, da, wp, clr);

         ce = creq && !m_pc;
         de = dreq && !m_pd;
         ewen = 32'h0;
         legal = 1'b0;
         wd = 1'b0;
         if (ce || de) begin
            if (ce && de) wd = prio ? 1'b1 : (m_last_dma ? 1'b0 : 1'b1);
            else          wd = de;
            wa = wd ? da : ca;
            legal = (int'(wa) < n_regs) && !wp[wa];
            if (legal) ewen = 32'h1 << wa;
            m_src = wd;
            m_last_dma = wd;
            if (!legal) begin
               if (!m_err || clr) m_ea = wa;
               m_err = 1'b1;
            end else if (clr) begin
               m_err = 1'b0;
               m_ea = 5'd0;
            end
         end else if (clr) begin
            m_err = 1'b0;
            m_ea = 5'd0;
         end
         m_pc = (ce || de) && !wd;
         m_pd = (ce || de) && wd;
         exp_b = {m_pc, m_pd, ewen, legal, m_src, m_err, m_ea};

         tick();
         get_out(inst, got);
         n_tests++;
         if (got !== exp_b) begin
            n_fail++;
            $display("FAIL random inst%0d cyc%0d got=%h exp=%h", inst, cyc, got, exp_b);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      set_in(1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      test_reset();
      test_round_robin();
      test_dma_prio();
      test_write_protect();
      test_out_of_range();
      test_reset_mid();
      test_random(0, 400);
      test_random(1, 400);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wen_arbiter.md
# regfile_wen_arbiter

Parametrised, registered successor to the register-file write-enable decoder. It arbitrates write requests from the CPU datapath and the DMA engine, decodes the winning register index into a one-hot write-enable vector, and enforces a per-register write-protect mask. It reports illegal writes through a sticky error flag. It sits between the CPU/DMA write ports and the register-file enable inputs.

## Interface
Parameters:
- `ADDR_W`, default 5: width of the register index.
- `N_REGS`, default 32: number of registers and width of `wen`; legal range 2..2^ADDR_W.
- `DMA_PRIO`, default 0: arbitration mode. 0 = round-robin; 1 = DMA has fixed priority.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU write request; held until `cpu_gnt`.
- `cpu_addr` in ADDR_W: CPU target register index; stable while `cpu_req` is high.
- `cpu_gnt` out 1: one-cycle pulse when the CPU request is consumed.
- `dma_req` in 1: DMA write request; held until `dma_gnt`.
- `dma_addr` in ADDR_W: DMA target register index.
- `dma_gnt` out 1: one-cycle pulse when the DMA request is consumed.
- `wp_mask` in N_REGS: bit i = 1 write-protects register i.
- `wen` out N_REGS: registered one-hot write enable; all zero when no legal write is issued.
- `wen_valid` out 1: high when `wen` carries a legal one-hot write.
- `wen_src` out 1: source of the current grant (0 = CPU, 1 = DMA).
- `err` out 1: sticky illegal-write flag.
- `err_addr` out ADDR_W: index of the first illegal write since the last clear.
- `err_clr` in 1: synchronous clear of `err` and `err_addr`.

## Operation
- **Eligibility:** a requester is eligible when its `req` is high and its own `gnt` is low in the same cycle. The request still visible while its grant is high is the one being consumed, and it is never issued twice.
- **Arbitration:**
  - With one eligible requester, that requester wins.
  - With both eligible and `DMA_PRIO=1`, DMA wins.
  - With both eligible and `DMA_PRIO=0`, the requester that did not win the most recent grant wins. The `last_winner` register updates on every grant and resets to DMA, so the CPU wins the first contest.
- **Issue (registered, next edge):**
  - The winner's `gnt` pulses high for one cycle.
  - `wen_src` takes the winner's identity.
  - If the winner's address is below `N_REGS` and `wp_mask[addr]` is 0:
    - `wen` gets bit `addr` set and all other bits cleared.
    - `wen_valid` goes high.
  - Otherwise the request is illegal:
    - `wen` goes to all zeros and `wen_valid` to 0.
    - The grant is still pulsed, so the request is consumed.
    - `err` is set.
    - `err_addr` captures the address only if `err` was previously 0.
- **Idle:** with no eligible requester, `wen`, `wen_valid`, `cpu_gnt` and `dma_gnt` are 0 next cycle. `wen_src` holds its value.
- **`wp_mask`:** sampled in the decision cycle. Changes take effect on the next decision.
- **Error clear vs. new error:** when `err_clr` and a new illegal write occur in the same cycle, the new error wins. `err` stays 1 and `err_addr` loads the new address.

## Timing
- **Reset state:** all outputs are 0 (`wen`, `wen_valid`, `wen_src`, `cpu_gnt`, `dma_gnt`, `err`, `err_addr`) and `last_winner` is DMA.
- **Reset mid-operation:** an asynchronous `rst` clears everything immediately. Pending requests are not granted during reset. Requesters still holding `req` after release are arbitrated normally.
- **Latency:** a request sampled at edge N produces `gnt` and `wen` during cycle N+1. `wen` is high for exactly one cycle per grant.
- **Throughput:**
  - A single requester achieves at most one grant every 2 cycles.
  - Two alternating requesters achieve one grant per cycle.
  - Round-robin bounds the wait to one grant of the other source.
- **Handshake:** `req` and `addr` must remain stable until the cycle `gnt` is high. A requester may drop `req` or present a new `addr` in the cycle after `gnt`.
- **Datapath:** no combinational path from any input to any output.

## Test plan
- **Reset values:** assert `rst` with `cpu_req=1` → all outputs 0. After release, first edge with `cpu_addr=3` → `wen=32'h00000008`, `wen_valid=1`, `cpu_gnt=1`, `wen_src=0`.
- **Round-robin contest (`DMA_PRIO=0`):** hold `cpu_req=dma_req=1` with addresses 1 and 2 → grants alternate CPU, DMA, CPU. `wen` sequence is `0x2`, `0x4`, `0x2`, with no idle cycle.
- **Fixed DMA priority (`DMA_PRIO=1`):** hold both requests → DMA granted every other cycle. The CPU is granted only in the cycles where DMA is ineligible (its `dma_gnt` is high).
- **Write-protect:** `wp_mask=32'h00000010`, CPU writes address 4 → `cpu_gnt=1`, `wen=0`, `wen_valid=0`, `err=1`, `err_addr=4`. A following DMA write to 5 gives `wen=0x20` while `err_addr` stays 4.
- **Out-of-range address:** with `N_REGS=24`, write to address 30 → error set with `err_addr=30`. `err_clr` together with an illegal write to 25 → `err=1`, `err_addr=25`.
- **Reset mid-transfer:** assert `rst` in the cycle `dma_req` is first sampled → no `dma_gnt`. With `req` still held, `dma_gnt` fires one cycle after release.
